imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction and immediate width.
REQ-002 SHALL have one clock and a synchronous, active-high reset; the clock port is clk and the reset port is rst.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-007 SHALL have port ImmSrc, input, 3, immediate type: 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal.
REQ-008 SHALL have port ImmValue, input, DATA_WIDTH, signed immediate value to encode.
REQ-009 SHALL have port BaseInstr, input, DATA_WIDTH, instruction carrying the non-immediate fields.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready.
REQ-012 SHALL have port Instr, output, DATA_WIDTH, assembled instruction.
REQ-013 SHALL have port ImmErr, output, 1, the immediate is not representable for ImmSrc.
REQ-014 SHALL have port EncCount, output, 16, results delivered.
REQ-015 SHALL have port ErrCount, output, 16, results delivered with ImmErr=1.

Function
REQ-016 SHALL place immediate bits at standard RV32I positions; all other bit positions pass through from BaseInstr.
- I: Instr[31:20]=imm[11:0].
- S: [31:25]=imm[11:5], [11:7]=imm[4:0].
- B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
- U: [31:12]=imm[31:12].
- J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-017 SHALL set ImmErr per type:
- I/S: imm[31:11] not all equal.
- B: imm[31:12] not all equal, or imm[0]=1.
- J: imm[31:20] not all equal, or imm[0]=1.
- U: imm[11:0]!=0.
- Illegal ImmSrc: always error.
REQ-018 SHALL, when ImmErr=1, force every immediate bit position of the selected type to 0; for illegal ImmSrc, Instr=BaseInstr.
REQ-019 SHALL be a two-stage pipeline.
- Stage 1 registers the inputs and the range check.
- Stage 2 registers Instr and ImmErr.
- Result out_valid exactly 2 cycles after acceptance when out_ready stays 1.
REQ-020 SHALL sustain one accept per cycle when out_ready=1 continuously.
REQ-021 SHALL use stall-all backpressure.
- Stage 2 advances when !out_valid || out_ready.
- Stage 1 advances into stage 2 on the same condition.
- in_ready = !s1_valid || stage-2 advance.
- in_ready is combinational from out_ready and state, and is forced to 0 while rst=1.
REQ-022 SHALL hold Instr and ImmErr stable while out_valid && !out_ready.
REQ-023 SHALL preserve order and never drop or duplicate a request.
REQ-024 SHALL increment EncCount on every output handshake, and ErrCount on handshakes with ImmErr=1; both saturate at 0xFFFF.
REQ-025 SHALL not let in_valid without in_ready, or changes to inputs while not accepted, affect state.

Reset
REQ-026 SHALL, on a clk edge with rst=1, clear both pipeline valid bits, EncCount and ErrCount.
REQ-027 SHALL drive out_valid=0, Instr=0, ImmErr=0 and in_ready=0 during reset.
REQ-028 SHALL discard in-flight requests when reset is asserted mid-operation, without a counter update.
REQ-029 SHALL accept a request on the first cycle after rst deasserts.

Verification
REQ-030 SHALL cover I-type: ImmSrc=000, ImmValue=0xFFFFF800, BaseInstr=0x00000013, out_ready=1 -> 2 cycles later Instr=0x80000013, ImmErr=0, EncCount=1.
REQ-031 SHALL cover B-type: ImmSrc=010, ImmValue=0x00000FFE, BaseInstr=0x00000063 -> Instr=0x7E000FE3, ImmErr=0.
REQ-032 SHALL cover U-type and J-type error.
- U: ImmSrc=011, ImmValue=0x12345000, BaseInstr=0x00000037 -> Instr=0x12345037.
- J: ImmSrc=100, ImmValue=0x00000003, BaseInstr=0x0000006F -> Instr=0x0000006F, ImmErr=1, ErrCount=1.
REQ-033 SHALL cover backpressure: out_ready=0, three requests offered back-to-back -> two accepted, in_ready=0 on the third.
- Then out_ready=1 -> all three delivered in order, no duplicates, EncCount=3.
REQ-034 SHALL cover reset mid-operation: rst pulsed with both stages valid -> next cycle out_valid=0, counters 0, and no stale result after release.
REQ-035 SHALL cover saturation: preload 65535 handshakes, then one more -> EncCount stays 0xFFFF.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage RV32I immediate encoder with valid/ready handshakes.
// Stage 1 holds the request and its range check; stage 2 holds the assembled instruction.
module imm_encoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            ImmSrc,
  input  logic [DATA_WIDTH-1:0] ImmValue,
  input  logic [DATA_WIDTH-1:0] BaseInstr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic                  ImmErr,
  output logic [15:0]           EncCount,
  output logic [15:0]           ErrCount
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;

  // True when every bit from lsb upward equals the sign bit.
  function automatic logic sext_fits(input logic [DATA_WIDTH-1:0] v, input int unsigned lsb);
    logic [DATA_WIDTH-1:0] hi;
    hi = $signed(v) >>> lsb;
    return (hi == {DATA_WIDTH{1'b0}}) || (hi == {DATA_WIDTH{1'b1}});
  endfunction

  function automatic logic range_err(input logic [2:0] src, input logic [DATA_WIDTH-1:0] v);
    logic err;
    case (src)
      SRC_I, SRC_S: err = !sext_fits(v, 32'd11);
      SRC_B:        err = !sext_fits(v, 32'd12) || v[0];
      SRC_U:        err = (v[11:0] != 12'd0);
      SRC_J:        err = !sext_fits(v, 32'd20) || v[0];
      default:      err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] encode(input logic [2:0] src,
                                                   input logic [DATA_WIDTH-1:0] imm,
                                                   input logic [DATA_WIDTH-1:0] base,
                                                   input logic err);
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] m;
    r = base;
    m = err ? {DATA_WIDTH{1'b0}} : imm;
    case (src)
      SRC_I: r[31:20] = m[11:0];
      SRC_S: begin
        r[31:25] = m[11:5];
        r[11:7]  = m[4:0];
      end
      SRC_B: begin
        r[31]    = m[12];
        r[30:25] = m[10:5];
        r[11:8]  = m[4:1];
        r[7]     = m[11];
      end
      SRC_U: r[31:12] = m[31:12];
      SRC_J: begin
        r[31]    = m[20];
        r[30:21] = m[10:1];
        r[20]    = m[11];
        r[19:12] = m[19:12];
      end
      default: r = base;
    endcase
    return r;
  endfunction

  logic                  s1_valid_r;
  logic [2:0]            s1_src_r;
  logic [DATA_WIDTH-1:0] s1_imm_r;
  logic [DATA_WIDTH-1:0] s1_base_r;
  logic                  s1_err_r;
  logic                  adv2_s;
  logic                  accept_s;

  // Stall-all handshake: the whole pipe moves only when the output slot frees up.
  always_comb begin
    adv2_s = !out_valid || out_ready;
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      in_ready = !s1_valid_r || adv2_s;
    end
    accept_s = in_valid && in_ready;
  end

  // Stage 1: capture the request and its range check.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_src_r   <= 3'd0;
      s1_imm_r   <= {DATA_WIDTH{1'b0}};
      s1_base_r  <= {DATA_WIDTH{1'b0}};
      s1_err_r   <= 1'b0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (accept_s) begin
        s1_src_r  <= ImmSrc;
        s1_imm_r  <= ImmValue;
        s1_base_r <= BaseInstr;
        s1_err_r  <= range_err(ImmSrc, ImmValue);
      end
    end
  end

  // Stage 2: assemble the instruction; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Instr     <= {DATA_WIDTH{1'b0}};
      ImmErr    <= 1'b0;
    end else if (adv2_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        Instr  <= encode(s1_src_r, s1_imm_r, s1_base_r, s1_err_r);
        ImmErr <= s1_err_r;
      end
    end
  end

  // Saturating delivery counters, stepped on each output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      EncCount <= 16'd0;
      ErrCount <= 16'd0;
    end else if (out_valid && out_ready) begin
      if (EncCount != 16'hFFFF) begin
        EncCount <= EncCount + 16'd1;
      end
      if (ImmErr && (ErrCount != 16'hFFFF)) begin
        ErrCount <= ErrCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and randomized checks of imm_encoder against a
// value-range reference model and a FIFO scoreboard.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_src;
  logic [31:0] imm_value;
  logic [31:0] base_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        imm_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_enc = 0;
  int exp_err = 0;

  logic        obs_acc, obs_dlv, obs_ready, obs_ovalid, obs_err;
  logic [31:0] obs_instr;
  logic [15:0] obs_enc, obs_errc;

  always #5 clk = ~clk;

  imm_encoder #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(imm_src), .ImmValue(imm_value), .BaseInstr(base_instr),
    .out_valid(out_valid), .out_ready(out_ready), .Instr(instr),
    .ImmErr(imm_err), .EncCount(enc_count), .ErrCount(err_count)
  );

  // Reference: representability from signed value ranges, fields by shift/mask.
  function automatic void model(input logic [2:0] src, input logic [31:0] imm,
                                input logic [31:0] base, output logic [31:0] ins,
                                output logic err);
    logic signed [31:0] v;
    logic [31:0] mask, field;
    v = imm;
    case (src)
      3'd0: begin
        err = (v < -2048) || (v > 2047);
        mask = 32'hFFF00000; field = (imm & 32'hFFF) << 20;
      end
      3'd1: begin
        err = (v < -2048) || (v > 2047);
        mask = 32'hFE000F80;
        field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      3'd2: begin
        err = (v < -4096) || (v > 4095) || imm[0];
        mask = 32'hFE000F80;
        field = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'd1) << 7);
      end
      3'd3: begin
        err = (imm & 32'hFFF) != 32'd0;
        mask = 32'hFFFFF000; field = imm & 32'hFFFFF000;
      end
      3'd4: begin
        err = (v < -1048576) || (v > 1048575) || imm[0];
        mask = 32'hFFFFF000;
        field = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12);
      end
      default: begin
        err = 1'b1; mask = 32'd0; field = 32'd0;
      end
    endcase
    if (err) field = 32'd0;
    ins = (base & ~mask) | field;
  endfunction

  function automatic logic [15:0] sat16(input int n);
    logic [31:0] t;
    t = n;
    return (n > 65535) ? 16'hFFFF : t[15:0];
  endfunction

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: r = $urandom;
      1: r = $urandom_range(0, 10000) - 5000;
      2: r = $urandom_range(0, 32'h400000) - 32'h200000;
      default: r = $urandom & 32'hFFFFF000;
    endcase
    if ($urandom_range(0, 1) == 1) r[0] = 1'b0;
    return r;
  endfunction

  // One clock: observe at the falling edge, return #1 after the rising edge.
  task automatic cycle();
    @(negedge clk);
    obs_acc = in_valid && in_ready;
    obs_dlv = out_valid && out_ready;
    obs_ready = in_ready;
    obs_ovalid = out_valid;
    obs_instr = instr;
    obs_err = imm_err;
    obs_enc = enc_count;
    obs_errc = err_count;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    exp_enc = 0; exp_err = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    imm_src = 3'd0; imm_value = 32'd5; base_instr = 32'h13;
    for (int c = 0; c < 2; c++) begin
      cycle();
      if (c == 1) begin
        total_cnt++; if (obs_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b want 0", obs_ready); else pass_cnt++;
        total_cnt++; if (obs_ovalid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", obs_ovalid); else pass_cnt++;
        total_cnt++; if (obs_instr !== 32'd0) $display("FAIL rst_instr: got %h want 0", obs_instr); else pass_cnt++;
        total_cnt++; if (obs_err !== 1'b0) $display("FAIL rst_imm_err: got %0b want 0", obs_err); else pass_cnt++;
        total_cnt++; if (obs_enc !== 16'd0) $display("FAIL rst_enc_count: got %0d want 0", obs_enc); else pass_cnt++;
        total_cnt++; if (obs_errc !== 16'd0) $display("FAIL rst_err_count: got %0d want 0", obs_errc); else pass_cnt++;
      end
    end
    exp_enc = 0; exp_err = 0;
  endtask

  task automatic test_directed();
    logic [2:0]  vs[4];
    logic [31:0] vi[4], vb[4], vx[4];
    logic        ve[4];
    vs = '{3'd0, 3'd2, 3'd3, 3'd4};
    vi = '{32'hFFFFF800, 32'h00000FFE, 32'h12345000, 32'h00000003};
    vb = '{32'h00000013, 32'h00000063, 32'h00000037, 32'h0000006F};
    vx = '{32'h80000013, 32'h7E000FE3, 32'h12345037, 32'h0000006F};
    ve = '{1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imm_src = vs[i]; imm_value = vi[i]; base_instr = vb[i]; in_valid = 1'b1;
      cycle();
      total_cnt++; if (obs_acc !== 1'b1) $display("FAIL dir_accept[%0d]: got %0b want 1", i, obs_acc); else pass_cnt++;
      total_cnt++; if (obs_enc !== sat16(exp_enc)) $display("FAIL dir_enc_count[%0d]: got %0d want %0d", i, obs_enc, exp_enc); else pass_cnt++;
      in_valid = 1'b0;
      cycle();
      total_cnt++; if (obs_ovalid !== 1'b0) $display("FAIL dir_early_valid[%0d]: got %0b want 0", i, obs_ovalid); else pass_cnt++;
      cycle();
      total_cnt++; if (obs_ovalid !== 1'b1) $display("FAIL dir_latency[%0d]: got %0b want 1", i, obs_ovalid); else pass_cnt++;
      total_cnt++; if (obs_instr !== vx[i]) $display("FAIL dir_instr[%0d]: got %h want %h", i, obs_instr, vx[i]); else pass_cnt++;
      total_cnt++; if (obs_err !== ve[i]) $display("FAIL dir_imm_err[%0d]: got %0b want %0b", i, obs_err, ve[i]); else pass_cnt++;
      exp_enc++;
      if (ve[i]) exp_err++;
    end
    cycle();
    total_cnt++; if (obs_enc !== sat16(exp_enc)) $display("FAIL dir_enc_final: got %0d want %0d", obs_enc, exp_enc); else pass_cnt++;
    total_cnt++; if (obs_errc !== sat16(exp_err)) $display("FAIL dir_err_final: got %0d want %0d", obs_errc, exp_err); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [2:0]  vs[3];
    logic [31:0] vi[3], vb[3], e_ins[3];
    logic        e_err[3];
    int idx, dl;
    apply_reset();
    vs = '{3'd0, 3'd1, 3'd3};
    vi = '{32'd5, 32'hFFFFFFFC, 32'hABCDE000};
    vb = '{32'h00000013, 32'h00000023, 32'h00000037};
    for (int i = 0; i < 3; i++) model(vs[i], vi[i], vb[i], e_ins[i], e_err[i]);
    idx = 0; dl = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin imm_src = vs[idx]; imm_value = vi[idx]; base_instr = vb[idx]; end
      out_ready = (c >= 4);
      cycle();
      if (c == 2 || c == 3) begin
        total_cnt++; if (obs_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %0b want 0", c, obs_ready); else pass_cnt++;
        total_cnt++; if (obs_instr !== e_ins[0]) $display("FAIL bp_hold[%0d]: got %h want %h", c, obs_instr, e_ins[0]); else pass_cnt++;
      end
      if (c == 2) begin
        total_cnt++; if (idx !== 2) $display("FAIL bp_accepted: got %0d want 2", idx); else pass_cnt++;
      end
      if (obs_dlv) begin
        total_cnt++;
        if (dl >= 3) $display("FAIL bp_extra_output: got %h want none", obs_instr);
        else if (obs_instr !== e_ins[dl] || obs_err !== e_err[dl])
          $display("FAIL bp_order[%0d]: got %h/%0b want %h/%0b", dl, obs_instr, obs_err, e_ins[dl], e_err[dl]);
        else pass_cnt++;
        dl++;
      end
      if (obs_acc) idx++;
    end
    total_cnt++; if (dl !== 3) $display("FAIL bp_delivered: got %0d want 3", dl); else pass_cnt++;
    total_cnt++; if (obs_enc !== 16'd3) $display("FAIL bp_enc_count: got %0d want 3", obs_enc); else pass_cnt++;
    exp_enc = 3;
  endtask

  task automatic test_random();
    logic [31:0] q_ins[$];
    logic        q_err[$];
    logic [31:0] m_ins, held_ins;
    logic        m_err, held, held_err;
    held = 1'b0; held_ins = 32'd0; held_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      imm_src = 3'($urandom_range(0, 7));
      imm_value = rand_imm();
      base_instr = $urandom;
      cycle();
      if (held) begin
        total_cnt++;
        if (obs_ovalid !== 1'b1 || obs_instr !== held_ins || obs_err !== held_err)
          $display("FAIL rnd_hold[%0d]: got %0b/%h/%0b want 1/%h/%0b", c, obs_ovalid, obs_instr, obs_err, held_ins, held_err);
        else pass_cnt++;
      end
      if (obs_dlv) begin
        total_cnt++;
        if (q_ins.size() == 0) $display("FAIL rnd_spurious[%0d]: got %h want none", c, obs_instr);
        else begin
          m_ins = q_ins.pop_front(); m_err = q_err.pop_front();
          if (obs_instr !== m_ins || obs_err !== m_err)
            $display("FAIL rnd_result[%0d]: got %h/%0b want %h/%0b", c, obs_instr, obs_err, m_ins, m_err);
          else pass_cnt++;
          exp_enc++;
          if (m_err) exp_err++;
        end
      end
      if (obs_acc) begin
        model(imm_src, imm_value, base_instr, m_ins, m_err);
        q_ins.push_back(m_ins); q_err.push_back(m_err);
      end
      held = obs_ovalid && !out_ready; held_ins = obs_instr; held_err = obs_err;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10 && q_ins.size() > 0; k++) begin
      cycle();
      if (obs_dlv) begin
        m_ins = q_ins.pop_front(); m_err = q_err.pop_front();
        total_cnt++;
        if (obs_instr !== m_ins || obs_err !== m_err)
          $display("FAIL rnd_drain[%0d]: got %h/%0b want %h/%0b", k, obs_instr, obs_err, m_ins, m_err);
        else pass_cnt++;
        exp_enc++;
        if (m_err) exp_err++;
      end
    end
    total_cnt++; if (q_ins.size() != 0) $display("FAIL rnd_lost: got %0d pending want 0", q_ins.size()); else pass_cnt++;
    cycle();
    total_cnt++; if (obs_enc !== sat16(exp_enc)) $display("FAIL rnd_enc_count: got %0d want %0d", obs_enc, exp_enc); else pass_cnt++;
    total_cnt++; if (obs_errc !== sat16(exp_err)) $display("FAIL rnd_err_count: got %0d want %0d", obs_errc, exp_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b0; imm_src = 3'd0; base_instr = 32'h13;
    imm_value = 32'd7; cycle();
    imm_value = 32'd9; cycle();
    rst = 1'b1;
    cycle();
    total_cnt++; if (obs_ready !== 1'b0) $display("FAIL mid_in_ready: got %0b want 0", obs_ready); else pass_cnt++;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_enc = 0; exp_err = 0;
    cycle();
    total_cnt++; if (obs_enc !== 16'd0 || obs_errc !== 16'd0) $display("FAIL mid_counters: got %0d/%0d want 0/0", obs_enc, obs_errc); else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) cycle();
      total_cnt++; if (obs_ovalid !== 1'b0) $display("FAIL mid_stale[%0d]: got %0b want 0", c, obs_ovalid); else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    int dcount;
    logic sat_seen, done, mid_done;
    dcount = 0; sat_seen = 1'b0; done = 1'b0; mid_done = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; imm_src = 3'b101;
    imm_value = 32'd0; base_instr = 32'h0000ABCD;
    for (int c = 0; c < 66000 && !done; c++) begin
      cycle();
      if (dcount == 1000 && !mid_done) begin
        mid_done = 1'b1;
        total_cnt++; if (obs_enc !== 16'd1000 || obs_errc !== 16'd1000) $display("FAIL sat_mid: got %0d/%0d want 1000/1000", obs_enc, obs_errc); else pass_cnt++;
      end
      if (sat_seen) begin
        done = 1'b1;
        total_cnt++; if (obs_enc !== 16'hFFFF || obs_errc !== 16'hFFFF) $display("FAIL sat_hold: got %h/%h want ffff/ffff", obs_enc, obs_errc); else pass_cnt++;
      end else if (dcount == 65535 && obs_dlv) begin
        sat_seen = 1'b1;
        total_cnt++; if (obs_enc !== 16'hFFFF || obs_errc !== 16'hFFFF) $display("FAIL sat_reach: got %h/%h want ffff/ffff", obs_enc, obs_errc); else pass_cnt++;
      end
      if (obs_dlv) dcount++;
    end
    total_cnt++; if (done !== 1'b1) $display("FAIL sat_timeout: got %0d handshakes want 65536", dcount); else pass_cnt++;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    imm_src = 3'd0; imm_value = 32'd0; base_instr = 32'd0;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
